// File: rtl/rotation_arbiter.sv
// Round-robin arbiter that shares one registered right-rotate datapath between two requesters.
// Optional build macro ROT_LEFT_EN adds dir0/dir1 inputs (1 = rotate left). WIDTH must equal 2**SHW.

module right_rotation #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   s,
    output logic [WIDTH-1:0] dout
);

    // Log-depth barrel: stage j rotates right by 2**j when s[j] is set.
    logic [WIDTH-1:0] stage [SHW+1];

    assign stage[0] = din;

    for (genvar j = 0; j < SHW; j++) begin : g_stage
        localparam int AMT = 2 ** j;
        assign stage[j+1] = s[j] ? {stage[j][AMT-1:0], stage[j][WIDTH-1:AMT]} : stage[j];
    end

    assign dout = stage[SHW];

endmodule

module rotation_arbiter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] din0,
    input  logic [SHW-1:0]   s0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din1,
    input  logic [SHW-1:0]   s1,
`ifdef ROT_LEFT_EN
    input  logic             dir0,
    input  logic             dir1,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] dout,
    output logic             done0,
    output logic             done1
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;       // 1: requester 1 wins a tie
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [SHW-1:0]   s_q, s_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic             pick;
    logic [SHW-1:0]   rot_amt;
    logic [WIDTH-1:0] rot_out;

`ifdef ROT_LEFT_EN
    logic dir_q, dir_d;

    // Left by s equals right by (WIDTH - s) mod WIDTH; with WIDTH == 2**SHW that is -s in SHW bits.
    assign rot_amt = dir_q ? -s_q : s_q;
`else
    assign rot_amt = s_q;
`endif

    right_rotation #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) u_rot (
        .din (din_q),
        .s   (rot_amt),
        .dout(rot_out)
    );

    assign pick = (req0 && req1) ? ptr_q : req1;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves one unassigned (no latch).
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        din_d   = din_q;
        s_d     = s_q;
        dout_d  = dout_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
`ifdef ROT_LEFT_EN
        dir_d   = dir_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = pick;
                    ptr_d   = ~pick;
                    state_d = BUSY;
                    if (pick) begin
                        gnt1_d = 1'b1;
                        din_d  = din1;
                        s_d    = s1;
`ifdef ROT_LEFT_EN
                        dir_d  = dir1;
`endif
                    end else begin
                        gnt0_d = 1'b1;
                        din_d  = din0;
                        s_d    = s0;
`ifdef ROT_LEFT_EN
                        dir_d  = dir0;
`endif
                    end
                end
            end
            BUSY: begin
                dout_d  = rot_out;
                done0_d = ~owner_q;
                done1_d = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the latched operands are plain registers, so they are reset like all other state
    // and the rotator input is well defined from the first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            din_q   <= '0;
            s_q     <= '0;
            dout_q  <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
`ifdef ROT_LEFT_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            din_q   <= din_d;
            s_q     <= s_d;
            dout_q  <= dout_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
`ifdef ROT_LEFT_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign busy  = (state_q == BUSY);
    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign dout  = dout_q;

endmodule

// File: tb/tb_rotation_arbiter.sv
// Scoreboard bench for rotation_arbiter: drivers queue expected results, a monitor checks
// grants, busy, done pulses and dout every cycle against an abstract arbitration model.

module tb_rotation_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] din0 = '0, din1 = '0;
    logic [2:0] s0 = '0, s1 = '0;
    logic       dir0 = 1'b0, dir1 = 1'b0;
    logic       gnt0, gnt1, busy, done0, done1;
    logic [7:0] dout;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    // Abstract arbiter model state.
    logic [1:0] prev_gnt = 2'b00;
    logic       ptr_m = 1'b0;
    logic [7:0] last_dout = '0;

    always #5 clk = ~clk;

    rotation_arbiter #(.WIDTH(8), .SHW(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req0 (req0),
        .din0 (din0),
        .s0   (s0),
        .req1 (req1),
        .din1 (din1),
        .s1   (s1),
`ifdef ROT_LEFT_EN
        .dir0 (dir0),
        .dir1 (dir1),
`endif
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .busy (busy),
        .dout (dout),
        .done0(done0),
        .done1(done1)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] ref_rot(input logic [7:0] d, input int s, input logic left);
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = left ? d[(i - s + 8) % 8] : d[(i + s) % 8];
        return r;
    endfunction

    // Raise a request at the current negedge, hold it until the grant is seen, then drop it.
    task automatic issue(input int k, input logic [7:0] d, input logic [2:0] s, input logic dir,
                         input logic [7:0] exp_v, input bit scramble);
        bit seen = 0;
        if (k == 0) begin
            din0 = d; s0 = s; dir0 = dir; exp_q0.push_back(exp_v); req0 = 1'b1;
        end else begin
            din1 = d; s1 = s; dir1 = dir; exp_q1.push_back(exp_v); req1 = 1'b1;
        end
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if ((k == 0 && gnt0) || (k == 1 && gnt1)) seen = 1;
        end
        if (k == 0) req0 = 1'b0; else req1 = 1'b0;
        if (!seen) begin
            n_chk++;
            n_err++;
            $display("FAIL grant_timeout: requester %0d got no grant within 12 cycles", k);
            if (k == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
        end else if (scramble) begin
            if (k == 0) begin din0 = ~d; s0 = s + 3'd3; dir0 = ~dir; end
            else        begin din1 = ~d; s1 = s + 3'd3; dir1 = ~dir; end
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: independent of the stimulus; pops the scoreboard on every done pulse.
    initial begin : monitor
        logic [1:0] exp_gnt;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_gnt  = 2'b00;
                ptr_m     = 1'b0;
                last_dout = '0;
                continue;
            end
            exp_gnt = 2'b00;
            if (prev_gnt == 2'b00) begin
                if (req0 && req1)  exp_gnt = ptr_m ? 2'b10 : 2'b01;
                else if (req0)     exp_gnt = 2'b01;
                else if (req1)     exp_gnt = 2'b10;
            end
            check("grant", {6'd0, gnt1, gnt0}, {6'd0, exp_gnt});
            check("busy", {7'd0, busy}, {7'd0, |exp_gnt});
            check("done", {6'd0, done1, done0}, {6'd0, prev_gnt});
            if (exp_gnt[0]) ptr_m = 1'b1;
            else if (exp_gnt[1]) ptr_m = 1'b0;
            if (prev_gnt != 2'b00) begin
                if (prev_gnt[1] ? (exp_q1.size() == 0) : (exp_q0.size() == 0)) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL scoreboard: done for requester %0d with no expected result", prev_gnt[1]);
                end else begin
                    e = prev_gnt[1] ? exp_q1.pop_front() : exp_q0.pop_front();
                    last_dout = e;
                end
            end
            check("dout", dout, last_dout);
            prev_gnt = exp_gnt;
        end
    end

    logic [7:0] sweep_exp [8] = '{8'b10000001, 8'b11000000, 8'b01100000, 8'b00110000,
                                  8'b00011000, 8'b00001100, 8'b00000110, 8'b00000011};

    initial begin : stimulus
        bit seen;
        rst_n = 1'b0;
        #1;
        check("reset_dout", dout, 8'd0);
        check("reset_flags", {3'd0, gnt0, gnt1, busy, done0, done1}, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // First transaction latency and the worked example.
        issue(0, 8'b10000001, 3'd1, 1'b0, 8'b11000000, 0);
        repeat (2) @(negedge clk);

        // Amount sweep for a single requester.
        for (int s = 0; s < 8; s++) begin
            issue(0, 8'b10000001, 3'(s), 1'b0, sweep_exp[s], 0);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // Simultaneous requests from a fresh reset: 0 first, then 1, then 0 favoured again.
        reset_dut();
        fork
            issue(1, 8'b11111110, 3'd1, 1'b0, 8'b01111111, 0);
            issue(0, 8'b10000001, 3'd7, 1'b0, 8'b00000011, 0);
        join
        repeat (2) @(negedge clk);
        fork
            issue(1, 8'h3c, 3'd2, 1'b0, ref_rot(8'h3c, 2, 1'b0), 0);
            issue(0, 8'h5a, 3'd5, 1'b0, ref_rot(8'h5a, 5, 1'b0), 0);
        join
        repeat (2) @(negedge clk);

        // Operands change right after the grant.
        issue(0, 8'b11111110, 3'd7, 1'b0, 8'b11111101, 1);
        repeat (3) @(negedge clk);

        // Reset while BUSY discards the operation.
        din0 = 8'ha5; s0 = 3'd3; req0 = 1'b1;
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (gnt0) seen = 1;
        end
        req0 = 1'b0;
        check("busy_before_reset", {7'd0, busy}, 8'd1);
        rst_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        #1;
        check("reset_in_busy_dout", dout, 8'd0);
        check("reset_in_busy_busy", {7'd0, busy}, 8'd0);
        @(posedge clk);
        #1;
        check("reset_in_busy_done", {6'd0, done1, done0}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fork
            issue(0, 8'h81, 3'd4, 1'b0, ref_rot(8'h81, 4, 1'b0), 0);
            issue(1, 8'h0f, 3'd6, 1'b0, ref_rot(8'h0f, 6, 1'b0), 0);
        join
        repeat (2) @(negedge clk);

`ifdef ROT_LEFT_EN
        issue(1, 8'b10000001, 3'd1, 1'b1, 8'b00000011, 0);
        @(negedge clk);
        issue(1, 8'b10000001, 3'd1, 1'b0, 8'b11000000, 0);
        repeat (2) @(negedge clk);
`endif

        // Randomized concurrent traffic from both requesters.
        fork
            for (int n = 0; n < 40; n++) begin
                logic [7:0] d;
                logic [2:0] s;
                logic       dr;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                d = 8'($urandom);
                s = 3'($urandom);
`ifdef ROT_LEFT_EN
                dr = 1'($urandom);
`else
                dr = 1'b0;
`endif
                issue(0, d, s, dr, ref_rot(d, int'(s), dr), 1'($urandom));
            end
            for (int n = 0; n < 40; n++) begin
                logic [7:0] d;
                logic [2:0] s;
                logic       dr;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                d = 8'($urandom);
                s = 3'($urandom);
`ifdef ROT_LEFT_EN
                dr = 1'($urandom);
`else
                dr = 1'b0;
`endif
                issue(1, d, s, dr, ref_rot(d, int'(s), dr), 1'($urandom));
            end
        join
        repeat (4) @(negedge clk);

        check("scoreboard_drained", 8'(exp_q0.size() + exp_q1.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
